// File: rtl/perceptron_trainable.sv
// N-input perceptron: one shared MAC for inference and a parallel
// saturating perceptron-rule update of all weights plus the bias.

module perceptron_wlane #(
  parameter int IN_W = 4,
  parameter int W_W  = 8
) (
  input  logic signed [W_W-1:0]  w_i,
  input  logic signed [IN_W-1:0] x_i,
  input  logic                   sub_i,
  output logic [W_W-1:0]         w_o
);
  localparam int S_W = W_W + IN_W + 1;
  localparam logic signed [S_W-1:0] MAXV = {{(S_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] MINV = {{(S_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};

  logic signed [S_W-1:0] w_ext, x_ext, sum;

  always_comb begin
    w_ext = {{(S_W-W_W){w_i[W_W-1]}}, w_i};
    x_ext = {{(S_W-IN_W){x_i[IN_W-1]}}, x_i};
    sum   = sub_i ? (w_ext - x_ext) : (w_ext + x_ext);
    if (sum > MAXV)      w_o = MAXV[W_W-1:0];
    else if (sum < MINV) w_o = MINV[W_W-1:0];
    else                 w_o = sum[W_W-1:0];
  end
endmodule

module perceptron_trainable #(
  parameter int N_INPUTS = 2,
  parameter int IN_W     = 4,
  parameter int W_W      = 8,
  parameter int W_INIT   = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [N_INPUTS*IN_W-1:0]                              x_vec,
  input  logic                                                  train,
  input  logic                                                  target,
  input  logic                                                  wload_en,
  input  logic [$clog2(N_INPUTS+1)-1:0]                         wload_idx,
  input  logic [W_W-1:0]                                        wload_data,
  output logic                                                  out_valid,
  output logic                                                  y,
  output logic [IN_W+W_W+$clog2(N_INPUTS+1)+1-1:0]              acc_out,
  output logic                                                  updated
);
  localparam int IDX_W  = $clog2(N_INPUTS+1);
  localparam int ACC_W  = IN_W + W_W + $clog2(N_INPUTS+1) + 1;
  localparam int PROD_W = IN_W + W_W;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DECIDE, S_UPDATE} state_t;

  state_t                             state_q, state_d;
  logic [N_INPUTS*IN_W-1:0]           x_q, x_d;
  logic                               train_q, train_d, target_q, target_d;
  logic [IDX_W-1:0]                   i_q, i_d;
  logic signed [ACC_W-1:0]            acc_q, acc_d, acc_out_q, acc_out_d;
  logic [N_INPUTS-1:0][W_W-1:0]       w_q, w_d, w_upd;
  logic [W_W-1:0]                     bias_q, bias_d, bias_upd;
  logic                               y_q, y_d, out_valid_q, out_valid_d;
  logic                               updated_q, updated_d;

  logic signed [W_W-1:0]              w_sel;
  logic signed [IN_W-1:0]             x_sel;
  logic signed [PROD_W-1:0]           prod;
  logic                               acc_pos;

  // Per-weight saturating update lanes; the bias is a lane whose input is +1.
  for (genvar g = 0; g < N_INPUTS; g++) begin : g_lane
    perceptron_wlane #(.IN_W(IN_W), .W_W(W_W)) u_lane (
      .w_i   (w_q[g]),
      .x_i   (x_q[g*IN_W +: IN_W]),
      .sub_i (!target_q),
      .w_o   (w_upd[g])
    );
  end

  perceptron_wlane #(.IN_W(2), .W_W(W_W)) u_bias (
    .w_i   (bias_q),
    .x_i   (2'sb01),
    .sub_i (!target_q),
    .w_o   (bias_upd)
  );

  always_comb begin
    w_sel = '0;
    x_sel = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (i_q == IDX_W'(k)) begin
        w_sel = w_q[k];
        x_sel = x_q[k*IN_W +: IN_W];
      end
    end
    prod    = w_sel * x_sel;
    acc_pos = (acc_q > 0);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    train_d     = train_q;
    target_d    = target_q;
    i_d         = i_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    w_d         = w_q;
    bias_d      = bias_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    updated_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Load is applied before capture so a same-edge write feeds this MAC.
        if (wload_en) begin
          for (int k = 0; k < N_INPUTS; k++)
            if (wload_idx == IDX_W'(k)) w_d[k] = wload_data;
          if (wload_idx == IDX_W'(N_INPUTS)) bias_d = wload_data;
        end
        if (in_valid) begin
          x_d      = x_vec;
          train_d  = train;
          target_d = target;
          acc_d    = {{(ACC_W-W_W){bias_d[W_W-1]}}, bias_d};
          i_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        i_d   = i_q + 1'b1;
        if (i_q == IDX_W'(N_INPUTS-1)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        y_d         = acc_pos;
        acc_out_d   = acc_q;
        out_valid_d = 1'b1;
        state_d     = (train_q && (acc_pos != target_q)) ? S_UPDATE : S_IDLE;
      end
      S_UPDATE: begin
        w_d       = w_upd;
        bias_d    = bias_upd;
        updated_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      train_q     <= 1'b0;
      target_q    <= 1'b0;
      i_q         <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      for (int k = 0; k < N_INPUTS; k++) w_q[k] <= W_W'(W_INIT);
      bias_q      <= '0;
      y_q         <= 1'b0;
      out_valid_q <= 1'b0;
      updated_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      train_q     <= train_d;
      target_q    <= target_d;
      i_q         <= i_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      w_q         <= w_d;
      bias_q      <= bias_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      updated_q   <= updated_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign acc_out   = acc_out_q;
  assign updated   = updated_q;
endmodule

// File: tb/tb_perceptron_trainable.sv
// Directed plus randomized checks of perceptron_trainable (N=2, IN_W=4, W_W=8)
// against an integer reference model of weights, bias and the learning rule.
module tb_perceptron_trainable;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  x_vec = '0;
  logic        train = 1'b0, target = 1'b0;
  logic        wload_en = 1'b0;
  logic [1:0]  wload_idx = '0;
  logic [7:0]  wload_data = '0;
  logic        out_valid, y, updated;
  logic [14:0] acc_out;

  int passed = 0, total = 0;
  int mw[2];
  int mbias;

  perceptron_trainable #(.N_INPUTS(2), .IN_W(4), .W_W(8), .W_INIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_vec(x_vec), .train(train), .target(target), .wload_en(wload_en),
    .wload_idx(wload_idx), .wload_data(wload_data), .out_valid(out_valid),
    .y(y), .acc_out(acc_out), .updated(updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sat8(input int v);
    return (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction

  function automatic int accv();
    return int'($signed(acc_out));
  endfunction

  task automatic model_reset();
    mw[0] = 1; mw[1] = 1; mbias = 0;
  endtask

  task automatic model_load(input int idx, input int data);
    if (idx < 2) mw[idx] = data;
    else if (idx == 2) mbias = data;
  endtask

  task automatic wload(input int idx, input int data);
    @(posedge clk); #1;
    wload_en = 1'b1; wload_idx = 2'(idx); wload_data = 8'(data);
    @(posedge clk); #1;
    wload_en = 1'b0;
    model_load(idx, data);
  endtask

  // wl_mode: 0 none, 1 write on the accepting edge, 2 write held during MAC (ignored)
  task automatic infer(input string tag, input int x0, input int x1, input bit tr,
                       input bit tg, input int wl_mode, input int wl_idx, input int wl_data);
    int sum, cyc;
    bit ey, eupd;
    logic [3:0] a, b;
    @(posedge clk); #1;
    if (wl_mode == 1) begin
      wload_en = 1'b1; wload_idx = 2'(wl_idx); wload_data = 8'(wl_data);
      model_load(wl_idx, wl_data);
    end
    sum  = mbias + mw[0] * x0 + mw[1] * x1;
    ey   = (sum > 0);
    eupd = tr && (ey != tg);
    a = 4'(x0); b = 4'(x1);
    x_vec = {b, a}; train = tr; target = tg; in_valid = 1'b1;
    chk({tag, ".ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; wload_en = 1'b0;
    x_vec = 8'($urandom); train = 1'($urandom); target = 1'($urandom);
    if (wl_mode == 2) begin
      wload_en = 1'b1; wload_idx = 2'(wl_idx); wload_data = 8'(wl_data);
    end
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) break;
    end
    wload_en = 1'b0;
    chk({tag, ".latency"}, cyc, 3);
    chk({tag, ".acc"}, accv(), sum);
    chk({tag, ".y"}, y, ey);
    @(posedge clk); #1;
    chk({tag, ".ovpulse"}, out_valid, 0);
    chk({tag, ".updated"}, updated, eupd);
    if (eupd) begin
      if (tg) begin
        mw[0] = sat8(mw[0] + x0); mw[1] = sat8(mw[1] + x1); mbias = sat8(mbias + 1);
      end else begin
        mw[0] = sat8(mw[0] - x0); mw[1] = sat8(mw[1] - x1); mbias = sat8(mbias - 1);
      end
    end
    chk({tag, ".held_y"}, y, ey);
  endtask

  initial begin
    int cyc, seen;
    model_reset();
    #12;
    chk("rst.ready", in_ready, 1);
    chk("rst.ov", out_valid, 0);
    chk("rst.y", y, 0);
    chk("rst.acc", accv(), 0);
    chk("rst.upd", updated, 0);
    rst_n = 1'b1;

    infer("t1", 2, 1, 0, 0, 0, 0, 0);
    infer("t2", -2, 2, 0, 0, 0, 0, 0);
    infer("t3", -1, -1, 1, 1, 0, 0, 0);
    infer("t3b", -1, -1, 0, 0, 0, 0, 0);

    wload(0, 125); wload(1, -128); wload(2, -128);
    infer("t4", 7, 7, 1, 1, 0, 0, 0);
    infer("t4w0", 1, 0, 0, 0, 0, 0, 0);
    infer("t4w1", 0, 1, 0, 0, 0, 0, 0);

    infer("t5mac", 1, 1, 0, 0, 2, 1, 50);
    infer("t5chk", 0, 1, 0, 0, 0, 0, 0);
    wload(3, 77);
    infer("t5idx3", 1, 1, 0, 0, 0, 0, 0);
    infer("t5same", 1, 1, 0, 0, 1, 0, 3);

    // Reset in the middle of a training transaction.
    @(posedge clk); #1;
    x_vec = {4'd7, 4'd7}; train = 1'b1; target = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6.ready", in_ready, 1);
    chk("t6.ov", out_valid, 0);
    chk("t6.y", y, 0);
    chk("t6.acc", accv(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      if (out_valid || updated) seen++;
    end
    chk("t6.nopulse", seen, 0);
    infer("t6w", 2, 1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int m;
      m = $urandom_range(0, 5);
      if (m == 5) wload($urandom_range(0, 3), $urandom_range(0, 255) - 128);
      infer($sformatf("rnd%0d", n), $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8,
            1'($urandom), 1'($urandom), (m > 2) ? m - 2 : 0,
            $urandom_range(0, 3), $urandom_range(0, 255) - 128);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/perceptron_trainable.md
Name: perceptron_trainable

Overview:
- Parametrised successor to the fixed two-input perceptron. N signed inputs, register-held signed weights plus bias.
- Time-multiplexed single-MAC inference; output y = 1 only when the weighted sum is strictly positive.
- Optional on-chip training with the perceptron learning rule (saturating update on misclassification).
- Sits behind the tile I/O wrapper; the wrapper maps ui_in/uio pins onto the handshake and load ports.

Parameters:
- N_INPUTS, 2, number of inputs (1..16)
- IN_W, 4, signed width of each input
- W_W, 8, signed width of each weight and the bias
- W_INIT, 1, reset value of every weight (bias resets to 0)
- Localparam ACC_W = IN_W + W_W + clog2(N_INPUTS+1) + 1, accumulator width (no overflow possible)
- Localparam IDX_W = clog2(N_INPUTS+1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector offered
- in_ready  out  1  high only in IDLE
- x_vec  in  N_INPUTS*IN_W  packed signed inputs, x[i] = x_vec[i*IN_W +: IN_W]
- train  in  1  sampled with x_vec; 1 = update weights on mismatch
- target  in  1  sampled with x_vec; desired y
- wload_en  in  1  direct weight/bias write strobe
- wload_idx  in  IDX_W  0..N-1 selects weight, N selects bias, >N ignored
- wload_data  in  W_W  signed value to write
- out_valid  out  1  one-cycle result pulse
- y  out  1  classification, held until next result
- acc_out  out  ACC_W  signed weighted sum incl. bias, held with y
- updated  out  1  pulses one cycle when a training update is applied

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, y=0, acc_out=0, updated=0
  - all weights = W_INIT, bias = 0
  - reset mid-operation aborts any transaction; no partial update survives
- FSM states: IDLE, MAC, DECIDE, UPDATE.
- IDLE:
  - on in_valid&&in_ready, capture x_vec, train and target
  - acc <= sign-extended bias, i <= 0, go to MAC
- MAC:
  - each cycle acc += w[i]*x[i] (full signed product, sign-extended), i++
  - after i = N_INPUTS-1, go to DECIDE; exactly N_INPUTS cycles
- DECIDE (one cycle):
  - y = (acc > 0) registered; acc == 0 gives y = 0; acc_out = acc
  - out_valid pulses at the edge leaving DECIDE
  - if train && y != target, go to UPDATE; else go to IDLE
- UPDATE (one cycle, all parallel):
  - if target=1: w[i] += x[i], bias += 1; if target=0: w[i] -= x[i], bias -= 1
  - every result saturates to [-2^(W_W-1), 2^(W_W-1)-1]
  - updated pulses; go to IDLE
- Latency: out_valid is high in the cycle N_INPUTS+1 clocks after the accepting edge. Throughput is one vector per N_INPUTS+2 cycles (N_INPUTS+3 with update).
- Weight load:
  - honoured only in IDLE; ignored (no effect) in every other state
  - if wload_en and an accepted in_valid share an IDLE edge, the write lands at that edge and the MAC uses the new value
- in_valid outside IDLE is ignored (in_ready=0); x_vec changes after acceptance have no effect.
- y and acc_out change only at the out_valid edge.

Test Plan (N_INPUTS=2, IN_W=4, W_W=8, W_INIT=1):
1. Reset, infer x=(2,1) -> out_valid exactly 3 cycles after the handshake edge; acc_out=3, y=1, updated=0, in_ready back high the next cycle.
2. Infer x=(-2,2) -> acc_out=0, y=0 (zero sum maps to 0).
3. Train x=(-1,-1), target=1 -> acc_out=-2, y=0, updated pulses. Weights become (0,0), bias 1. Re-infer the same x -> acc_out=1, y=1.
4. Saturation:
   - load w0=125, w1=-128, bias=-128 via wload (idx 0, 1, 2)
   - train x=(7,7), target=1 -> acc_out=-149, y=0
   - after update: w0=127 (saturated), w1=-121, bias=-127
5. wload_en idx=1, data=50 asserted during MAC -> ignored; next inference shows w1 unchanged. wload idx=3 in IDLE -> no register changes.
6. Drop rst_n for 1 cycle mid-MAC of a train transaction -> out_valid never pulses, in_ready=1 immediately, weights=W_INIT, bias=0, y=0, acc_out=0.
